decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
// - RV32I decode (D) stage. Sits between fetch/decode register and de_reg; produces every *D signal de_reg latches.
// - Holds the 32x32 integer register file; written by writeback (W), read combinationally.
// - Raises load-use stall; de_reg turns it into an E-stage bubble.
// PARAMETERS
// - XLEN     32  datapath / register width
// - NREGS    32  architectural registers; x0 hardwired to 0
// PORTS
// - CLK             in   1   clock, rising edge
// - NRST            in   1   reset, synchronous, active-low
// - instD           in   32  instruction in D; 32'd0 = bubble
// - reg_writeW      in   1   writeback enable
// - rdW             in   5   writeback destination
// - resultW         in   32  writeback data
// - mem_loadE       in   3   load code of instruction in E (0 = not a load)
// - rdE             in   5   destination of instruction in E
// - rs1D,rs2D,rdD   out  5   raw fields inst[19:15], [24:20], [11:7]
// - source1D/2D     out  32  register operands, W-bypassed
// - immD            out  32  sign-extended immediate
// - alu_codeD       out  6   {class[1:0], funct7b5, funct3}
// - alu_srcD        out  1   1 = operand B is immD
// - jump_codeD      out  2   0 none, 1 JAL, 2 JALR
// - branch_codeD    out  3   0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU
// - mem_storeD      out  2   0 none, 1 SB, 2 SH, 3 SW
// - mem_loadD       out  3   0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU
// - reg_writeD      out  1   instruction writes rd (forced 0 when rd==0)
// - cannot_predictD out  1   1 for JALR: target unknown at fetch
// - stall           out  1   load-use hazard; upstream holds, de_reg bubbles
// BEHAVIOUR
// - Register file: write on rising CLK when reg_writeW && rdW!=0; writes to x0 discarded.
// - !NRST sampled high-priority: all 32 regs cleared that edge, concurrent W write dropped.
// - Reads combinational, zero latency. Bypass: reg_writeW && rdW!=0 && rdW==rsX -> sourceX = resultW.
// - x0 always reads 0.
// - Outputs are combinational from instD plus regfile state. No output flops, so no reset value beyond:
//   after reset, all source reads return 0.
// - Immediates:
//   - I (OP-IMM, LOAD, JALR): sext inst[31:20]
//   - S: sext {inst[31:25], inst[11:7]}
//   - B: sext {inst[31], inst[7], inst[30:25], inst[11:8], 0}
//   - U: {inst[31:12], 12'b0}
//   - J: sext {inst[31], inst[19:12], inst[20], inst[30:21], 0}
//   - R-type: immD = 0
// - alu_code class field:
//   - 00 none
//   - 01 arith: OP/OP-IMM use funct3 and funct7b5. funct7b5 is 0 for OP-IMM except SRAI.
//     LOAD/STORE/JALR/JAL/branch use ADD = 6'b010000.
//   - 10 LUI (pass imm)
//   - 11 AUIPC (pc + imm)
// - alu_srcD = 1 for OP-IMM, LOAD, STORE, JALR, LUI, AUIPC.
// - Unknown opcode, unknown funct3 in LOAD/STORE/BRANCH, or instD == 0:
//   all control outputs (alu_code..cannot_predict) = 0. Fields/imm still driven.
// - Operand use:
//   - uses_rs1 for R, I, S, B.
//   - uses_rs2 for R, S, B.
//   - Neither for U, J, or bubble.
// - stall = (mem_loadE != 0) && (rdE != 0) &&
//   ((uses_rs1 && rdE == rs1D) || (uses_rs2 && rdE == rs2D)).
//   Stall is purely combinational; it holds as long as the condition holds.
// - Simultaneous stall and W write to the same reg: write still commits; bypass value is visible.
// STRUCTURE
// - Shared package rv32i_pkg: opcode localparams, ALU class constants,
//   JUMP_/BRANCH_/STORE_/LOAD_ code constants (shared with de_reg and execute).
// - One sub-module regfile_2r1w: 2 combinational read ports, 1 write port, x0 zero, W bypass, sync clear.
// - Decoder and hazard logic stay inline.
// TESTING
// - Reset, then read x1..x31 via add instructions -> source1D/2D = 0. stall = 0, all control 0 for instD = 0.
// - reg_writeW=1, rdW=5, resultW=0xDEADBEEF; same cycle instD = add x6,x5,x5
//   -> source1D = source2D = 0xDEADBEEF (bypass). Next cycle with W idle -> same values from storage.
// - Write rdW=0, resultW=0x1234, then read x0 -> 0.
//   Assert NRST=0 during a W write to x3 -> x3 reads 0 afterwards.
// - mem_loadE=3, rdE=7, instD = add x8,x7,x1 -> stall=1.
//   Change rdE=0 -> stall=0.
//   rdE=7, instD = lui x7,1 -> stall=0.
//   rdE=7, instD = sw x7,0(x2) -> stall=1.
// - instD=0xFFF10093 (addi x1,x2,-1) -> immD=0xFFFFFFFF, alu_codeD=0x10, alu_srcD=1, reg_writeD=1, rdD=1.
//   jalr x1,0(x2) -> jump_codeD=2, cannot_predictD=1.
// - instD=0x0020A423 (sw x2,8(x1)) -> mem_storeD=3, immD=8, reg_writeD=0.
//   Opcode 0x7F -> all control 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding constants: opcodes, ALU classes and the jump/branch/store/load
// codes that decode, de_reg and execute all agree on.
package rv32i_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [1:0] ALU_CLASS_NONE  = 2'b00;
  localparam logic [1:0] ALU_CLASS_ARITH = 2'b01;
  localparam logic [1:0] ALU_CLASS_LUI   = 2'b10;
  localparam logic [1:0] ALU_CLASS_AUIPC = 2'b11;
  localparam logic [5:0] ALU_ADD         = {ALU_CLASS_ARITH, 1'b0, 3'b000};

  localparam logic [1:0] JUMP_NONE = 2'd0;
  localparam logic [1:0] JUMP_JAL  = 2'd1;
  localparam logic [1:0] JUMP_JALR = 2'd2;

  localparam logic [2:0] BRANCH_NONE = 3'd0;
  localparam logic [2:0] BRANCH_BEQ  = 3'd1;
  localparam logic [2:0] BRANCH_BNE  = 3'd2;
  localparam logic [2:0] BRANCH_BLT  = 3'd3;
  localparam logic [2:0] BRANCH_BGE  = 3'd4;
  localparam logic [2:0] BRANCH_BLTU = 3'd5;
  localparam logic [2:0] BRANCH_BGEU = 3'd6;

  localparam logic [1:0] STORE_NONE = 2'd0;
  localparam logic [1:0] STORE_SB   = 2'd1;
  localparam logic [1:0] STORE_SH   = 2'd2;
  localparam logic [1:0] STORE_SW   = 2'd3;

  localparam logic [2:0] LOAD_NONE = 3'd0;
  localparam logic [2:0] LOAD_LB   = 3'd1;
  localparam logic [2:0] LOAD_LH   = 3'd2;
  localparam logic [2:0] LOAD_LW   = 3'd3;
  localparam logic [2:0] LOAD_LBU  = 3'd4;
  localparam logic [2:0] LOAD_LHU  = 3'd5;

endpackage

// File: rtl/decode_stage_if.sv
// Decoded D-stage bundle handed to de_reg. Purely combinational, no handshake:
// de_reg latches every field each cycle unless stall asks it to insert a bubble.
interface decode_stage_if #(parameter int XLEN = 32);
  logic [4:0]      rs1D;
  logic [4:0]      rs2D;
  logic [4:0]      rdD;
  logic [XLEN-1:0] source1D;
  logic [XLEN-1:0] source2D;
  logic [XLEN-1:0] immD;
  logic [5:0]      alu_codeD;
  logic            alu_srcD;
  logic [1:0]      jump_codeD;
  logic [2:0]      branch_codeD;
  logic [1:0]      mem_storeD;
  logic [2:0]      mem_loadD;
  logic            reg_writeD;
  logic            cannot_predictD;
  logic            stall;

  modport master (
    output rs1D, rs2D, rdD, source1D, source2D, immD, alu_codeD, alu_srcD,
           jump_codeD, branch_codeD, mem_storeD, mem_loadD, reg_writeD,
           cannot_predictD, stall
  );

  modport slave (
    input rs1D, rs2D, rdD, source1D, source2D, immD, alu_codeD, alu_srcD,
          jump_codeD, branch_codeD, mem_storeD, mem_loadD, reg_writeD,
          cannot_predictD, stall
  );
endinterface

// File: rtl/regfile_2r1w.sv
// Integer register file: two combinational read ports with writeback bypass,
// one write port, x0 hardwired to zero, synchronous active-low clear.
module regfile_2r1w
  import rv32i_pkg::*;
#(
  parameter int W = XLEN,
  parameter int N = NREGS
) (
  input  logic                 CLK,
  input  logic                 NRST,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] wa,
  input  logic [W-1:0]         wd,
  input  logic [$clog2(N)-1:0] ra1,
  input  logic [$clog2(N)-1:0] ra2,
  output logic [W-1:0]         rd1,
  output logic [W-1:0]         rd2
);
  localparam int AW = $clog2(N);

  logic [W-1:0] regs [N];
  logic         w_live;

  assign w_live = we && (wa != '0);

  // Reset outranks a concurrent write: the whole file is cleared that edge.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else if (w_live) begin
      regs[wa] <= wd;
    end
  end

  function automatic logic [W-1:0] read_port(input logic [AW-1:0] ra);
    if (ra == '0)                 return '0;
    else if (w_live && wa == ra)  return wd;
    else                          return regs[ra];
  endfunction

  assign rd1 = read_port(ra1);
  assign rd2 = read_port(ra2);
endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: instruction field extraction, immediate generation, control
// decode, register file read with W bypass, and load-use stall detection.
module decode_stage
  import rv32i_pkg::*;
(
  input  logic              CLK,
  input  logic              NRST,
  input  logic [XLEN-1:0]   instD,
  input  logic              reg_writeW,
  input  logic [4:0]        rdW,
  input  logic [XLEN-1:0]   resultW,
  input  logic [2:0]        mem_loadE,
  input  logic [4:0]        rdE,
  decode_stage_if.master    d_bus
);
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic [4:0] rs1, rs2, rd;

  assign opcode = instD[6:0];
  assign funct3 = instD[14:12];
  assign f7b5   = instD[30];
  assign rs1    = instD[19:15];
  assign rs2    = instD[24:20];
  assign rd     = instD[11:7];

  regfile_2r1w #(.W(XLEN), .N(NREGS)) u_regfile (
    .CLK  (CLK),
    .NRST (NRST),
    .we   (reg_writeW),
    .wa   (rdW),
    .wd   (resultW),
    .ra1  (rs1),
    .ra2  (rs2),
    .rd1  (d_bus.source1D),
    .rd2  (d_bus.source2D)
  );

  logic [XLEN-1:0] imm;

  always_comb begin
    imm = '0;
    unique case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: imm = {{20{instD[31]}}, instD[31:20]};
      OP_STORE:                 imm = {{20{instD[31]}}, instD[31:25], instD[11:7]};
      OP_BRANCH:                imm = {{19{instD[31]}}, instD[31], instD[7],
                                       instD[30:25], instD[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {instD[31:12], 12'b0};
      OP_JAL:                   imm = {{11{instD[31]}}, instD[31], instD[19:12],
                                       instD[20], instD[30:21], 1'b0};
      default:                  imm = '0;
    endcase
  end

  logic       valid, uses_rs1, uses_rs2;
  logic [5:0] alu_code;
  logic       alu_src, reg_write, cannot_predict;
  logic [1:0] jump_code, mem_store;
  logic [2:0] branch_code, mem_load;

  always_comb begin
    valid          = 1'b0;
    uses_rs1       = 1'b0;
    uses_rs2       = 1'b0;
    alu_code       = '0;
    alu_src        = 1'b0;
    reg_write      = 1'b0;
    cannot_predict = 1'b0;
    jump_code      = JUMP_NONE;
    mem_store      = STORE_NONE;
    branch_code    = BRANCH_NONE;
    mem_load       = LOAD_NONE;
    unique case (opcode)
      OP_LUI: begin
        valid = 1'b1; alu_code = {ALU_CLASS_LUI, 4'b0}; alu_src = 1'b1; reg_write = 1'b1;
      end
      OP_AUIPC: begin
        valid = 1'b1; alu_code = {ALU_CLASS_AUIPC, 4'b0}; alu_src = 1'b1; reg_write = 1'b1;
      end
      OP_JAL: begin
        valid = 1'b1; alu_code = ALU_ADD; jump_code = JUMP_JAL; reg_write = 1'b1;
      end
      OP_JALR: begin
        valid = 1'b1; alu_code = ALU_ADD; alu_src = 1'b1; jump_code = JUMP_JALR;
        reg_write = 1'b1; cannot_predict = 1'b1; uses_rs1 = 1'b1;
      end
      OP_BRANCH: begin
        unique case (funct3)
          3'b000:  branch_code = BRANCH_BEQ;
          3'b001:  branch_code = BRANCH_BNE;
          3'b100:  branch_code = BRANCH_BLT;
          3'b101:  branch_code = BRANCH_BGE;
          3'b110:  branch_code = BRANCH_BLTU;
          3'b111:  branch_code = BRANCH_BGEU;
          default: branch_code = BRANCH_NONE;
        endcase
        valid = (branch_code != BRANCH_NONE); alu_code = ALU_ADD;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_LOAD: begin
        unique case (funct3)
          3'b000:  mem_load = LOAD_LB;
          3'b001:  mem_load = LOAD_LH;
          3'b010:  mem_load = LOAD_LW;
          3'b100:  mem_load = LOAD_LBU;
          3'b101:  mem_load = LOAD_LHU;
          default: mem_load = LOAD_NONE;
        endcase
        valid = (mem_load != LOAD_NONE); alu_code = ALU_ADD; alu_src = 1'b1;
        reg_write = 1'b1; uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        unique case (funct3)
          3'b000:  mem_store = STORE_SB;
          3'b001:  mem_store = STORE_SH;
          3'b010:  mem_store = STORE_SW;
          default: mem_store = STORE_NONE;
        endcase
        valid = (mem_store != STORE_NONE); alu_code = ALU_ADD; alu_src = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_IMM: begin
        // Bit 30 is immediate payload for OP-IMM except when it selects SRAI.
        valid = 1'b1; alu_code = {ALU_CLASS_ARITH, (funct3 == 3'b101) && f7b5, funct3};
        alu_src = 1'b1; reg_write = 1'b1; uses_rs1 = 1'b1;
      end
      OP_REG: begin
        valid = 1'b1; alu_code = {ALU_CLASS_ARITH, f7b5, funct3}; reg_write = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      default: valid = 1'b0;
    endcase
    if (!valid) begin
      uses_rs1 = 1'b0; uses_rs2 = 1'b0; alu_code = '0; alu_src = 1'b0;
      reg_write = 1'b0; cannot_predict = 1'b0; jump_code = JUMP_NONE;
      mem_store = STORE_NONE; branch_code = BRANCH_NONE; mem_load = LOAD_NONE;
    end
  end

  assign d_bus.rs1D            = rs1;
  assign d_bus.rs2D            = rs2;
  assign d_bus.rdD             = rd;
  assign d_bus.immD            = imm;
  assign d_bus.alu_codeD       = alu_code;
  assign d_bus.alu_srcD        = alu_src;
  assign d_bus.jump_codeD      = jump_code;
  assign d_bus.branch_codeD    = branch_code;
  assign d_bus.mem_storeD      = mem_store;
  assign d_bus.mem_loadD       = mem_load;
  assign d_bus.reg_writeD      = reg_write && (rd != 5'd0);
  assign d_bus.cannot_predictD = cannot_predict;

  assign d_bus.stall = (mem_loadE != LOAD_NONE) && (rdE != 5'd0) &&
                       ((uses_rs1 && rdE == rs1) || (uses_rs2 && rdE == rs2));
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: driver pushes hand-computed expectations into a
// queue, a negedge monitor pops and compares them against the combinational outputs.
module tb_decode_stage;
  import rv32i_pkg::*;

  localparam int S_SRC1 = 0, S_SRC2 = 1, S_IMM = 2, S_ALU = 3, S_ASRC = 4, S_JUMP = 5,
                 S_BR = 6, S_ST = 7, S_LD = 8, S_RW = 9, S_CP = 10, S_STALL = 11,
                 S_RD = 12, S_RS1 = 13, S_RS2 = 14;

  logic        CLK = 1'b0;
  logic        NRST = 1'b0;
  logic [31:0] instD = '0;
  logic        reg_writeW = 1'b0;
  logic [4:0]  rdW = '0;
  logic [31:0] resultW = '0;
  logic [2:0]  mem_loadE = '0;
  logic [4:0]  rdE = '0;

  decode_stage_if #(.XLEN(32)) d_bus ();

  decode_stage dut (
    .CLK        (CLK),
    .NRST       (NRST),
    .instD      (instD),
    .reg_writeW (reg_writeW),
    .rdW        (rdW),
    .resultW    (resultW),
    .mem_loadE  (mem_loadE),
    .rdE        (rdE),
    .d_bus      (d_bus)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // scoreboard
  logic [31:0] exp_q[$];
  int          sel_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  function automatic logic [31:0] get_sig(input int sel);
    case (sel)
      S_SRC1:  return d_bus.source1D;
      S_SRC2:  return d_bus.source2D;
      S_IMM:   return d_bus.immD;
      S_ALU:   return {26'd0, d_bus.alu_codeD};
      S_ASRC:  return {31'd0, d_bus.alu_srcD};
      S_JUMP:  return {30'd0, d_bus.jump_codeD};
      S_BR:    return {29'd0, d_bus.branch_codeD};
      S_ST:    return {30'd0, d_bus.mem_storeD};
      S_LD:    return {29'd0, d_bus.mem_loadD};
      S_RW:    return {31'd0, d_bus.reg_writeD};
      S_CP:    return {31'd0, d_bus.cannot_predictD};
      S_STALL: return {31'd0, d_bus.stall};
      S_RD:    return {27'd0, d_bus.rdD};
      S_RS1:   return {27'd0, d_bus.rs1D};
      default: return {27'd0, d_bus.rs2D};
    endcase
  endfunction

  function automatic string sig_name(input int sel);
    case (sel)
      S_SRC1: return "source1D";    S_SRC2: return "source2D";  S_IMM: return "immD";
      S_ALU:  return "alu_codeD";   S_ASRC: return "alu_srcD";  S_JUMP: return "jump_codeD";
      S_BR:   return "branch_codeD"; S_ST:  return "mem_storeD"; S_LD:  return "mem_loadD";
      S_RW:   return "reg_writeD";  S_CP:   return "cannot_predictD";
      S_STALL: return "stall";      S_RD:   return "rdD";       S_RS1: return "rs1D";
      default: return "rs2D";
    endcase
  endfunction

  // monitor
  always @(negedge CLK) begin
    while (exp_q.size() != 0) begin
      logic [31:0] e, a;
      int          s;
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      a = get_sig(s);
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL %s inst=%08h: got %08h expected %08h", sig_name(s), instD, a, e);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic exp(input int sel, input logic [31:0] val);
    sel_q.push_back(sel);
    exp_q.push_back(val);
  endtask

  task automatic exp_ctrl(input logic [5:0] alu, input logic asrc, input logic [1:0] jmp,
                          input logic [2:0] br, input logic [1:0] st, input logic [2:0] ld,
                          input logic rw, input logic cp);
    exp(S_ALU, {26'd0, alu}); exp(S_ASRC, {31'd0, asrc}); exp(S_JUMP, {30'd0, jmp});
    exp(S_BR, {29'd0, br});   exp(S_ST, {30'd0, st});     exp(S_LD, {29'd0, ld});
    exp(S_RW, {31'd0, rw});   exp(S_CP, {31'd0, cp});
  endtask

  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  initial begin
    int waited;
    // reset
    NRST = 1'b0;
    step(); step();
    NRST = 1'b1;

    // all registers read zero after reset; bubble decodes to nothing
    for (int i = 1; i < 32; i++) begin
      instD = r_add(5'd1, 5'(i), 5'((i % 31) + 1));
      exp(S_SRC1, 32'd0); exp(S_SRC2, 32'd0);
      step();
    end
    instD = 32'd0;
    exp(S_STALL, 32'd0);
    exp_ctrl(6'h00, 0, 0, 0, 0, 0, 0, 0);
    step();

    // same-cycle W bypass, then the stored value
    reg_writeW = 1'b1; rdW = 5'd5; resultW = 32'hDEADBEEF;
    instD = r_add(5'd6, 5'd5, 5'd5);
    exp(S_SRC1, 32'hDEADBEEF); exp(S_SRC2, 32'hDEADBEEF);
    exp(S_RD, 32'd6); exp(S_RS1, 32'd5); exp(S_RS2, 32'd5);
    exp_ctrl(6'h10, 0, 0, 0, 0, 0, 1, 0);
    step();
    reg_writeW = 1'b0; rdW = 5'd0; resultW = 32'd0;
    exp(S_SRC1, 32'hDEADBEEF); exp(S_SRC2, 32'hDEADBEEF);
    step();

    // sub x6,x5,x1 : funct7b5 set, x1 still zero
    instD = 32'h40128333;
    exp(S_ALU, 32'h18); exp(S_SRC1, 32'hDEADBEEF); exp(S_SRC2, 32'd0);
    step();

    // writes to x0 are neither bypassed nor stored
    reg_writeW = 1'b1; rdW = 5'd0; resultW = 32'h1234;
    instD = r_add(5'd1, 5'd0, 5'd0);
    exp(S_SRC1, 32'd0); exp(S_SRC2, 32'd0);
    step();
    reg_writeW = 1'b0;
    exp(S_SRC1, 32'd0);
    step();

    // reset wins over a concurrent W write; x5 cleared as well
    NRST = 1'b0; reg_writeW = 1'b1; rdW = 5'd3; resultW = 32'hA5A5A5A5;
    step();
    NRST = 1'b1; reg_writeW = 1'b0; rdW = 5'd0;
    instD = r_add(5'd1, 5'd3, 5'd5);
    exp(S_SRC1, 32'd0); exp(S_SRC2, 32'd0);
    step();

    // load-use hazard
    mem_loadE = 3'd3; rdE = 5'd7;
    instD = r_add(5'd8, 5'd7, 5'd1); exp(S_STALL, 32'd1); step();
    rdE = 5'd0;                      exp(S_STALL, 32'd0); step();
    rdE = 5'd7;
    instD = 32'h000013B7;            exp(S_STALL, 32'd0);             // lui x7,1
    exp(S_IMM, 32'h1000); exp_ctrl(6'h20, 1, 0, 0, 0, 0, 1, 0);       step();
    instD = 32'h00712023;            exp(S_STALL, 32'd1); step();      // sw x7,0(x2)
    instD = r_add(5'd8, 5'd1, 5'd7); exp(S_STALL, 32'd1); step();
    instD = 32'h000003EF;            exp(S_STALL, 32'd0); step();      // jal x7,0
    mem_loadE = 3'd0;
    instD = r_add(5'd8, 5'd7, 5'd7); exp(S_STALL, 32'd0); step();
    rdE = 5'd0;

    // W write coincident with a stall on the same register
    mem_loadE = 3'd1; rdE = 5'd9; reg_writeW = 1'b1; rdW = 5'd9; resultW = 32'h0BADF00D;
    instD = r_add(5'd8, 5'd9, 5'd0);
    exp(S_STALL, 32'd1); exp(S_SRC1, 32'h0BADF00D);
    step();
    mem_loadE = 3'd0; rdE = 5'd0; reg_writeW = 1'b0; rdW = 5'd0;
    exp(S_SRC1, 32'h0BADF00D);
    step();

    // immediates and control
    instD = 32'hFFF10093;  // addi x1,x2,-1
    exp(S_IMM, 32'hFFFFFFFF); exp(S_RD, 32'd1); exp(S_RS1, 32'd2);
    exp_ctrl(6'h10, 1, 0, 0, 0, 0, 1, 0); step();
    instD = 32'h40010093;  // addi x1,x2,0x400 : bit 30 is immediate, not funct7b5
    exp(S_IMM, 32'h400); exp(S_ALU, 32'h10); step();
    instD = 32'h40315093;  // srai x1,x2,3
    exp(S_ALU, 32'h1D); exp(S_IMM, 32'h403); step();
    instD = 32'h000100E7;  // jalr x1,0(x2)
    exp_ctrl(6'h10, 1, 2, 0, 0, 0, 1, 1); step();
    instD = 32'h0020A423;  // sw x2,8(x1)
    exp(S_IMM, 32'd8); exp_ctrl(6'h10, 1, 0, 0, 3, 0, 0, 0); step();
    instD = 32'h00209463;  // bne x1,x2,8
    exp(S_IMM, 32'd8); exp_ctrl(6'h10, 0, 0, 2, 0, 0, 0, 0); step();
    instD = 32'hFE000EE3;  // beq x0,x0,-4
    exp(S_IMM, 32'hFFFFFFFC); exp(S_BR, 32'd1); step();
    instD = 32'h008000EF;  // jal x1,8
    exp(S_IMM, 32'd8); exp_ctrl(6'h10, 0, 1, 0, 0, 0, 1, 0); step();
    instD = 32'h0040A283;  // lw x5,4(x1)
    exp(S_IMM, 32'd4); exp_ctrl(6'h10, 1, 0, 0, 0, 3, 1, 0); step();
    instD = 32'h00001117;  // auipc x2,1
    exp(S_IMM, 32'h1000); exp_ctrl(6'h30, 1, 0, 0, 0, 0, 1, 0); step();
    instD = 32'h00208033;  // add x0,x1,x2 : rd==0 suppresses the write
    exp(S_RW, 32'd0); step();
    instD = 32'h00003003;  // LOAD with reserved funct3
    exp_ctrl(6'h00, 0, 0, 0, 0, 0, 0, 0); step();
    mem_loadE = 3'd3; rdE = 5'd7;
    instD = 32'h0073807F;  // opcode 0x7F, rs1=x7
    exp_ctrl(6'h00, 0, 0, 0, 0, 0, 0, 0); exp(S_STALL, 32'd0); step();
    mem_loadE = 3'd0; rdE = 5'd0; instD = 32'd0;

    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(posedge CLK);
      waited++;
    end
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
